mem_refill_ctrl: RTL and testbench

MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

---
 rtl/mem_refill_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_refill_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_ctrl.sv
// mem_refill_ctrl: cache block refill controller on a word-serial memory bus.
// A dirty victim block is written back (words 0..7) before the missing block
// is read. Word k of a block lives in bits [255-32k -: 32].
// Optional: define MEMCTRL_CWF_EN for critical-word-first reads, which start
// at the missing word and wrap modulo the block size.
module mem_refill_ctrl #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req,
   input  logic                      victim_dirty,
   input  logic [ADDR_W-1:0]         victim_addr,
   input  logic [BLOCK_WORDS*32-1:0] victim_data,
   input  logic [ADDR_W-1:0]         fill_addr,
   output logic                      busy,
   output logic                      done,
   output logic [BLOCK_WORDS*32-1:0] fill_data,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [31:0]               mem_wdata,
   input  logic [31:0]               mem_rdata,
   input  logic                      mem_ack
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);
   localparam int OFF_W = IDX_W + 2;
   localparam int BLK_W = BLOCK_WORDS * 32;
   localparam int HI_W  = ADDR_W - OFF_W;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

   state_t            state;
   logic [IDX_W-1:0]  beat;     // beats completed in the current phase
   logic [IDX_W-1:0]  start;    // first word index of the read phase
   logic [HI_W-1:0]   vhi;      // victim block number (offset bits dropped)
   logic [HI_W-1:0]   fhi;      // fill block number
   logic [BLK_W-1:0]  vdata;

   logic [IDX_W-1:0]  beat_nxt;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  rd_idx_nxt;

   // Offset bits are dropped by design: memory traffic is always block-aligned.
   logic unused_bits;
   assign unused_bits = ^{fill_addr[OFF_W-1:0], victim_addr[OFF_W-1:0]};

   // Word index arithmetic wraps naturally in IDX_W bits.
   assign beat_nxt   = beat + IDX_W'(1);
   assign rd_idx     = start + beat;
   assign rd_idx_nxt = start + beat_nxt;

   function automatic logic [31:0] word_of(input logic [BLK_W-1:0] blk,
                                           input logic [IDX_W-1:0] k);
      return blk[BLK_W-32-32*int'(k) +: 32];
   endfunction

   // Control FSM with registered bus and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat      <= '0;
         start     <= '0;
         vhi       <= '0;
         fhi       <= '0;
         vdata     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fill_data <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               done    <= 1'b0;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               if (req) begin
                  vhi   <= victim_addr[ADDR_W-1:OFF_W];
                  fhi   <= fill_addr[ADDR_W-1:OFF_W];
                  vdata <= victim_data;
`ifdef MEMCTRL_CWF_EN
                  start <= fill_addr[OFF_W-1:2];
`else
                  start <= '0;
`endif
                  beat  <= '0;
                  busy  <= 1'b1;
                  state <= victim_dirty ? WB : RD;
               end
            end

            // Write back victim words 0..7; first cycle only launches beat 0.
            WB: begin
               if (!mem_req) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {vhi, beat, 2'b00};
                  mem_wdata <= word_of(vdata, beat);
               end else if (mem_ack) begin
                  if (beat == LAST) begin
                     // Roll straight into the read phase without a bus gap.
                     beat     <= '0;
                     state    <= RD;
                     mem_we   <= 1'b0;
                     mem_addr <= {fhi, start, 2'b00};
                  end else begin
                     beat      <= beat_nxt;
                     mem_addr  <= {vhi, beat_nxt, 2'b00};
                     mem_wdata <= word_of(vdata, beat_nxt);
                  end
               end
            end

            // Read the fill block, storing each word at its own position.
            RD: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= {fhi, start, 2'b00};
               end else if (mem_ack) begin
                  fill_data[BLK_W-32-32*int'(rd_idx) +: 32] <= mem_rdata;
                  if (beat == LAST) begin
                     beat    <= '0;
                     mem_req <= 1'b0;
                     done    <= 1'b1;
                     state   <= DONE;
                  end else begin
                     beat     <= beat_nxt;
                     mem_addr <= {fhi, rd_idx_nxt, 2'b00};
                  end
               end
            end

            // One-cycle completion; req seen here waits for IDLE.
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               state   <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Scoreboard bench for mem_refill_ctrl: expected bus beats are queued when a
// request is driven and popped as the memory model acknowledges each beat.
module tb_mem_refill_ctrl;

   localparam int AW = 32;
`ifdef MEMCTRL_CWF_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           req;
   logic           victim_dirty;
   logic [AW-1:0]  victim_addr;
   logic [255:0]   victim_data;
   logic [AW-1:0]  fill_addr;
   logic           busy;
   logic           done;
   logic [255:0]   fill_data;
   logic           mem_req;
   logic           mem_we;
   logic [AW-1:0]  mem_addr;
   logic [31:0]    mem_wdata;
   logic [31:0]    mem_rdata;
   logic           mem_ack;

   mem_refill_ctrl #(.BLOCK_WORDS(8), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .victim_dirty(victim_dirty),
      .victim_addr(victim_addr), .victim_data(victim_data),
      .fill_addr(fill_addr), .busy(busy), .done(done), .fill_data(fill_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   beat_t       exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          beats = 0;
   int          done_cnt = 0;
   int          ack_mode = 0;   // 0: always ack, 1: ack every 3rd cycle
   logic        held_v = 1'b0;
   logic [31:0] h_addr, h_wdata;
   logic        h_we;

   function automatic logic [255:0] build_fill(input logic [31:0] base);
      logic [255:0] f;
      for (int k = 0; k < 8; k++) f[255-32*k -: 32] = base + 32'(4*k);
      return f;
   endfunction

   function automatic logic [255:0] build_victim();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[255-32*k -: 32] = 32'hA0 + 32'(k);
      return v;
   endfunction

   task automatic push_wb(input logic [31:0] va, input logic [255:0] vd);
      beat_t b;
      for (int k = 0; k < 8; k++) begin
         b.we = 1'b1; b.addr = {va[31:5], 5'd0} + 32'(4*k);
         b.data = vd[255-32*k -: 32];
         exp_q.push_back(b);
      end
   endtask

   task automatic push_rd(input logic [31:0] fa);
      beat_t b;
      int    s;
      s = CWF ? int'(fa[4:2]) : 0;
      for (int j = 0; j < 8; j++) begin
         b.we = 1'b0; b.addr = {fa[31:5], 5'd0} + 32'(4*((s + j) % 8));
         b.data = '0;
         exp_q.push_back(b);
      end
   endtask

   // One cycle: memory model response plus beat scoreboard, away from posedge.
   task automatic tick();
      logic  ack;
      beat_t e;
      @(negedge clk);
      cyc++;
      ack = (ack_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      mem_ack   = ack;
      mem_rdata = mem_addr;
      if (mem_req === 1'b1) begin
         if (held_v) begin
            tests++;
            if (mem_addr !== h_addr || mem_we !== h_we || (h_we && mem_wdata !== h_wdata)) begin
               fails++;
               $display("FAIL stall_stable: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                        mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wdata);
            end
         end
         if (ack) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_beat: addr=%h we=%b, required no beat", mem_addr, mem_we);
            end else begin
               e = exp_q.pop_front();
               if (mem_addr !== e.addr || mem_we !== e.we || (e.we && mem_wdata !== e.data)) begin
                  fails++;
                  $display("FAIL beat: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                           mem_addr, mem_we, mem_wdata, e.addr, e.we, e.data);
               end
            end
            beats++;
            held_v = 1'b0;
         end else begin
            held_v = 1'b1; h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
         end
      end else begin
         held_v = 1'b0;
      end
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic drive_req(input logic dirty, input logic [31:0] va,
                            input logic [255:0] vd, input logic [31:0] fa);
      req = 1'b1; victim_dirty = dirty; victim_addr = va;
      victim_data = vd; fill_addr = fa;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (done !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL done_timeout: no done within %0d cycles", bound);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 1'b0; victim_dirty = 1'b0; victim_addr = '0;
      victim_data = '0; fill_addr = '0; mem_ack = 1'b1; mem_rdata = '0;
      tick(); tick();
      tests++;
      if ({busy, done, mem_req, mem_we} !== 4'b0) begin
         fails++;
         $display("FAIL reset_ctrl: busy/done/req/we=%b, required 0000", {busy, done, mem_req, mem_we});
      end
      tests++;
      if (mem_addr !== '0 || mem_wdata !== '0 || fill_data !== '0) begin
         fails++;
         $display("FAIL reset_data: addr=%h wdata=%h fill_nonzero=%b, required zeros",
                  mem_addr, mem_wdata, |fill_data);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_clean_miss();
      int n;
      logic [255:0] fd;
      ack_mode = 0; beats = 0; done_cnt = 0;
      push_rd(32'h104);
      drive_req(1'b0, 32'h0, '0, 32'h104);
      tick();
      req = 1'b0;
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL clean_busy: busy=%b, required 1", busy); end
      wait_done(40, n);
      n++;
      tests++;
      if (n !== 10) begin fails++; $display("FAIL clean_latency: done at cycle %0d, required 10", n); end
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL clean_busy_done: busy=%b, required 1", busy); end
      fd = fill_data;
      tests++;
      if (fd[255:224] !== 32'h100 || fd !== build_fill(32'h100)) begin
         fails++;
         $display("FAIL clean_fill: word0=%h, required 00000100 and full block match", fd[255:224]);
      end
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL clean_pulse: done=%b busy=%b, required 0 0", done, busy);
      end
      tick(); tick();
      tests++;
      if (fill_data !== fd || beats != 8 || exp_q.size() != 0 || done_cnt != 1) begin
         fails++;
         $display("FAIL clean_end: beats=%0d left=%0d dones=%0d stable=%b, required 8 0 1 1",
                  beats, exp_q.size(), done_cnt, fill_data === fd);
      end
   endtask

   task automatic run_dirty(input string nm, input int mode, input logic [31:0] va,
                            input logic [31:0] fa, input int bound);
      int n;
      logic [255:0] vd;
      vd = build_victim();
      ack_mode = mode; beats = 0; done_cnt = 0;
      push_wb(va, vd);
      push_rd(fa);
      drive_req(1'b1, va, vd, fa);
      tick();
      req = 1'b0;
      wait_done(bound, n);
      tests++;
      if (fill_data !== build_fill({fa[31:5], 5'd0})) begin
         fail_fill: begin
            fails++;
            $display("FAIL %s_fill: word0=%h, required %h", nm, fill_data[255:224], {fa[31:5], 5'd0});
         end
      end
      tick(); tick(); tick();
      tests++;
      if (beats != 16 || exp_q.size() != 0 || done_cnt != 1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_end: beats=%0d left=%0d dones=%0d busy=%b, required 16 0 1 0",
                  nm, beats, exp_q.size(), done_cnt, busy);
      end
   endtask

   task automatic test_dirty_miss();
      run_dirty("dirty", 0, 32'h80, 32'h200, 60);
   endtask

   task automatic test_stall();
      run_dirty("stall", 1, 32'h3C4, 32'h51C, 200);
   endtask

   task automatic test_cwf();
      int n;
      ack_mode = 0; beats = 0; done_cnt = 0;
      push_rd(32'h114);
      drive_req(1'b0, 32'h0, '0, 32'h114);
      tick();
      req = 1'b0;
      wait_done(40, n);
      tests++;
      if (fill_data !== build_fill(32'h100) || beats != 8 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL cwf: word0=%h beats=%0d left=%0d, required 00000100 8 0",
                  fill_data[255:224], beats, exp_q.size());
      end
      tick();
   endtask

   task automatic test_reset_mid_wb();
      int n;
      ack_mode = 0; beats = 0;
      push_wb(32'h80, build_victim());
      drive_req(1'b1, 32'h80, build_victim(), 32'h200);
      tick();
      req = 1'b0;
      n = 0;
      while (beats < 4 && n < 20) begin tick(); n++; end
      tests++;
      if (beats != 4) begin fails++; $display("FAIL rst_mid_reach: beats=%0d, required 4", beats); end
      rst_n = 1'b0;
      #1;
      tests++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_abort: req=%b busy=%b we=%b, required 0 0 0", mem_req, busy, mem_we);
      end
      exp_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      run_dirty("rst_fresh", 0, 32'h40, 32'h300, 60);
   endtask

   task automatic test_req_held();
      int n;
      ack_mode = 0; beats = 0; done_cnt = 0;
      push_rd(32'h240);
      drive_req(1'b0, 32'h0, '0, 32'h240);
      tick();
      wait_done(40, n);
      push_rd(32'h240);
      tick();
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL held_no_queue: busy=%b done=%b, required 0 0", busy, done);
      end
      tick();
      req = 1'b0;
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL held_second_accept: busy=%b, required 1", busy); end
      wait_done(40, n);
      tick(); tick();
      tests++;
      if (done_cnt != 2 || beats != 16 || exp_q.size() != 0) begin
         fails++;
         $display("FAIL held_end: dones=%0d beats=%0d left=%0d, required 2 16 0",
                  done_cnt, beats, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_clean_miss();
      test_dirty_miss();
      test_stall();
      test_cwf();
      test_reset_mid_wb();
      test_req_held();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
